// File: rtl/i2s_sample_bridge.sv
// System-clock side of the I2S transceiver: frame-event synchronizer, rx FIFO
// with first-word fall-through, and a tx staging register released on frame events.
module i2s_sample_bridge #(
  parameter int sample_size = 16,
  parameter int fifo_depth  = 4,
  parameter int sync_stages = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   i2s_rx_valid,
  input  logic [sample_size-1:0] i2s_rx_l,
  input  logic [sample_size-1:0] i2s_rx_r,
  output logic [sample_size-1:0] i2s_tx_l,
  output logic [sample_size-1:0] i2s_tx_r,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [sample_size-1:0] out_l,
  output logic [sample_size-1:0] out_r,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [sample_size-1:0] in_l,
  input  logic [sample_size-1:0] in_r,
  output logic                   overrun,
  output logic                   underrun,
  input  logic                   clear_flags
);

  localparam int addr_w = $clog2(fifo_depth);
  localparam int cnt_w  = addr_w + 1;
  localparam int word_w = 2 * sample_size;

  // ---------------- frame event ----------------
  logic [sync_stages-1:0] sync_q, sync_d;
  logic [sync_stages-1:0] fill_q, fill_d;
  logic                   prev_q, armed_q, armed_d, evt_q, evt_d;
  logic                   synced;

  assign synced = sync_q[sync_stages-1];

  // fill_q tracks which synchronizer stages hold post-reset samples, so the
  // cleared chain is never mistaken for a real low level when arming.
  always_comb begin
    sync_d  = {sync_q[sync_stages-2:0], i2s_rx_valid};
    fill_d  = {fill_q[sync_stages-2:0], 1'b1};
    armed_d = armed_q | (fill_q[sync_stages-1] & ~synced);
    evt_d   = synced & ~prev_q & armed_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q  <= '0;
      fill_q  <= '0;
      prev_q  <= 1'b0;
      armed_q <= 1'b0;
      evt_q   <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      fill_q  <= fill_d;
      prev_q  <= synced;
      armed_q <= armed_d;
      evt_q   <= evt_d;
    end
  end

  // ---------------- rx FIFO ----------------
  logic [word_w-1:0] mem_q [fifo_depth];
  logic [addr_w-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [cnt_w-1:0]  count_q, count_d;
  logic [word_w-1:0] head;
  logic              fifo_full, pop, push, ovr_set;

  assign fifo_full = (count_q == cnt_w'(fifo_depth));
  assign out_valid = (count_q != '0);
  assign pop       = out_valid & out_ready;
  // A full FIFO still accepts a frame when the head leaves in the same cycle.
  assign push      = evt_q & (~fifo_full | pop);
  assign ovr_set   = evt_q & fifo_full & ~pop;
  assign head      = mem_q[rd_ptr_q];
  assign out_l     = out_valid ? head[word_w-1:sample_size] : '0;
  assign out_r     = out_valid ? head[sample_size-1:0]      : '0;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {i2s_rx_l, i2s_rx_r};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // ---------------- tx staging ----------------
  logic [sample_size-1:0] stage_l_q, stage_l_d, stage_r_q, stage_r_d;
  logic [sample_size-1:0] tx_l_q, tx_l_d, tx_r_q, tx_r_d;
  logic                   stage_full_q, stage_full_d, load, unr_set;
  logic                   overrun_q, overrun_d, underrun_q, underrun_d;

  assign in_ready = ~stage_full_q & ~reset;
  assign load     = in_valid & in_ready;
  assign unr_set  = evt_q & ~stage_full_q;
  assign i2s_tx_l = tx_l_q;
  assign i2s_tx_r = tx_r_q;
  assign overrun  = overrun_q;
  assign underrun = underrun_q;

  // Load only happens while staging is empty, so an evt in the same cycle
  // sees the old (empty) staging and the new frame waits for the next evt.
  always_comb begin
    stage_l_d    = stage_l_q;
    stage_r_d    = stage_r_q;
    stage_full_d = stage_full_q;
    tx_l_d       = tx_l_q;
    tx_r_d       = tx_r_q;
    if (evt_q && stage_full_q) begin
      tx_l_d       = stage_l_q;
      tx_r_d       = stage_r_q;
      stage_full_d = 1'b0;
    end
    if (load) begin
      stage_l_d    = in_l;
      stage_r_d    = in_r;
      stage_full_d = 1'b1;
    end
    overrun_d  = ovr_set | (overrun_q  & ~clear_flags);
    underrun_d = unr_set | (underrun_q & ~clear_flags);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stage_l_q    <= '0;
      stage_r_q    <= '0;
      stage_full_q <= 1'b0;
      tx_l_q       <= '0;
      tx_r_q       <= '0;
      overrun_q    <= 1'b0;
      underrun_q   <= 1'b0;
    end else begin
      stage_l_q    <= stage_l_d;
      stage_r_q    <= stage_r_d;
      stage_full_q <= stage_full_d;
      tx_l_q       <= tx_l_d;
      tx_r_q       <= tx_r_d;
      overrun_q    <= overrun_d;
      underrun_q   <= underrun_d;
    end
  end

endmodule
